// File: rtl/count_line_parser.sv
// count_line_parser
//   Decodes an ASCII stream of lines "count=<decimal>\n" into binary values.
//   Malformed lines are dropped and reported via err/err_code/err_count.
//
// Handshake: a character moves when in_valid && in_ready, and a value moves
// when out_valid && out_ready. A source holds in_data while in_valid is high
// and in_ready is low. out_data stays stable while out_valid is high and
// out_ready is low.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   character handshake, in_data = ASCII character
//   out_valid/out_ready value handshake, out_data = decoded value
//   err                 one-cycle pulse when a line is rejected
//   err_code            cause of last error (1 prefix, 2 bad char/empty, 3 overflow)
//   err_count           rejected-line count, saturating at 255
//   dbg_state           current FSM state (0 PREFIX, 1 DIGITS, 2 SKIP, 3 EMIT)
module count_line_parser #(
  parameter int VALUE_WIDTH = 8,
  parameter int MAX_DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VALUE_WIDTH-1:0] out_data,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [7:0]             err_count,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int AW = VALUE_WIDTH + 4;
  localparam logic [AW-1:0] MAX_VAL = AW'({VALUE_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    S_PREFIX = 2'd0,
    S_DIGITS = 2'd1,
    S_SKIP   = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [2:0]             idx, idx_n;
  logic [VALUE_WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [VALUE_WIDTH-1:0] out_data_n;
  logic                   err_n;
  logic [1:0]             err_code_n;
  logic [7:0]             err_count_n;

  logic                   in_xfer;
  logic                   is_cr, is_lf, is_digit;
  logic [AW-1:0]          sum;
  logic [7:0]             pchar;

  function automatic logic [7:0] prefix_char(input logic [2:0] i);
    case (i)
      3'd0:    prefix_char = 8'h63; // c
      3'd1:    prefix_char = 8'h6F; // o
      3'd2:    prefix_char = 8'h75; // u
      3'd3:    prefix_char = 8'h6E; // n
      3'd4:    prefix_char = 8'h74; // t
      default: prefix_char = 8'h3D; // =
    endcase
  endfunction

  assign in_ready  = (state != S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign dbg_state = state;

  assign in_xfer  = in_valid && in_ready;
  assign is_cr    = (in_data == 8'h0D);
  assign is_lf    = (in_data == 8'h0A);
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign pchar    = prefix_char(idx);
  // Wide enough that acc*10+9 never wraps, so the overflow compare is exact.
  assign sum      = AW'(acc) * AW'(10) + AW'(in_data[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PREFIX;
      idx       <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      err_count <= 8'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_data  <= out_data_n;
      err       <= err_n;
      err_code  <= err_code_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    acc_n       = acc;
    cnt_n       = cnt;
    out_data_n  = out_data;
    err_n       = 1'b0;
    err_code_n  = err_code;

    case (state)
      S_PREFIX: begin
        if (in_xfer && !is_cr) begin
          if (in_data == pchar) begin
            if (idx == 3'd5) begin
              state_n = S_DIGITS;
              idx_n   = '0;
              acc_n   = '0;
              cnt_n   = '0;
            end else begin
              idx_n = idx + 3'd1;
            end
          end else if (is_lf) begin
            // A bare LF is an empty line; a partial prefix ending in LF is an error.
            if (idx != 3'd0) begin
              err_n      = 1'b1;
              err_code_n = 2'd1;
            end
            idx_n = '0;
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'd1;
            idx_n      = '0;
            state_n    = S_SKIP;
          end
        end
      end
      S_DIGITS: begin
        if (in_xfer && !is_cr) begin
          if (is_digit) begin
            if ((cnt == CW'(MAX_DIGITS)) || (sum > MAX_VAL)) begin
              err_n      = 1'b1;
              err_code_n = 2'd3;
              state_n    = S_SKIP;
            end else begin
              acc_n = sum[VALUE_WIDTH-1:0];
              cnt_n = cnt + CW'(1);
            end
          end else if (is_lf) begin
            if (cnt == '0) begin
              err_n      = 1'b1;
              err_code_n = 2'd2;
              state_n    = S_PREFIX;
            end else begin
              out_data_n = acc;
              state_n    = S_EMIT;
            end
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
            state_n    = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (in_xfer && is_lf) begin
          state_n = S_PREFIX;
        end
      end
      default: begin // S_EMIT
        if (out_ready) begin
          state_n = S_PREFIX;
        end
      end
    endcase

    err_count_n = err_count;
    if (err_n && (err_count != 8'hFF)) begin
      err_count_n = err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_count_line_parser.sv
// Testbench for count_line_parser: directed scenarios plus randomized lines,
// checked against a line-level reference model and an expected-value queue.
module tb_count_line_parser;

  localparam int VW = 8;
  localparam int MD = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_data;
  logic          err;
  logic [1:0]    err_code;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  count_line_parser #(.VALUE_WIDTH(VW), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_code(err_code), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad = 0;
  int            model_err_cnt = 0;
  int            stalls = 0;
  int            obs_viol = 0;
  bit            rand_ready = 1'b0;
  bit            rand_gaps = 1'b0;
  logic [VW-1:0] exp_q[$];
  logic [9:0]    exp_err_q[$];   // {err_code, err_count}
  logic [VW-1:0] obs_q[$];
  logic [9:0]    obs_err_q[$];

  // Observation: sample on the falling edge; a value is taken at the next
  // rising edge when out_valid && out_ready are seen together here.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready === out_valid) obs_viol++;
      if (out_valid && out_ready) obs_q.push_back(out_data);
      if (err) obs_err_q.push_back({err_code, err_count});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  task automatic push_err(input int code);
    if (model_err_cnt < 255) model_err_cnt++;
    exp_err_q.push_back({code[1:0], model_err_cnt[7:0]});
  endtask

  // Interprets one line (without its LF) as text and records the outcome.
  task automatic model_line(input string s);
    logic [7:0] t[$];
    string      pre = "count=";
    int         val = 0;
    int         nd = 0;
    int         d;
    bit         bad_pre = 1'b0;
    for (int i = 0; i < s.len(); i++) if (s[i] != 8'h0D) t.push_back(s[i]);
    if (t.size() == 0) return;
    for (int i = 0; i < 6; i++) if (i >= t.size() || t[i] != pre[i]) bad_pre = 1'b1;
    if (bad_pre) begin push_err(1); return; end
    if (t.size() == 6) begin push_err(2); return; end
    for (int i = 6; i < t.size(); i++) begin
      if (t[i] < 8'h30 || t[i] > 8'h39) begin push_err(2); return; end
      d = int'(t[i]) - 48;
      if (nd == MD || val * 10 + d > (1 << VW) - 1) begin push_err(3); return; end
      val = val * 10 + d;
      nd++;
    end
    exp_q.push_back(VW'(val));
  endtask

  // ---------------- drivers ----------------
  task automatic send_char(input logic [7:0] c);
    bit done = 1'b0;
    if (rand_gaps) begin
      repeat ($urandom_range(0, 1)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = c;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) stalls++;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    model_line(s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(8'h0A);
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_err_q.delete(); obs_q.delete(); obs_err_q.delete();
    obs_viol = 0;
    stalls = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (obs_q.size() >= exp_q.size() && obs_err_q.size() >= exp_err_q.size()) break;
      @(posedge clk);
      #1;
    end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_err_cnt = 0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d want=0", err_code); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_sb();
    send_line("count=0");
    send_line("count=255");
    drain();
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL basic_count got=%0d want=2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0] !== 8'd0) begin bad++; $display("FAIL basic_v0 got=%0d want=0", obs_q[0]); end
      total++; if (obs_q[1] !== 8'd255) begin bad++; $display("FAIL basic_v1 got=%0d want=255", obs_q[1]); end
    end
    total++; if (obs_err_q.size() !== 0 || err_count !== 8'd0) begin bad++; $display("FAIL basic_no_err got=%0d/%0d want=0/0", obs_err_q.size(), err_count); end
    total++; if (obs_viol !== 0 || stalls !== 0) begin bad++; $display("FAIL basic_hs got=%0d/%0d want=0/0", obs_viol, stalls); end
  endtask

  task automatic test_errors();
    clear_sb();
    send_line("count=256");
    drain();
    total++; if (err_code !== 2'd3 || err_count !== 8'd1) begin bad++; $display("FAIL overflow got=%0d/%0d want=3/1", err_code, err_count); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL overflow_no_out got=%0d want=0", obs_q.size()); end
    send_line("count=9");
    send_line("cnt=5");
    drain();
    total++; if (err_code !== 2'd1 || err_count !== 8'd2) begin bad++; $display("FAIL prefix got=%0d/%0d want=1/2", err_code, err_count); end
    send_line("count=7");
    send_line("count=");
    send_line("count=1x");
    drain();
    total++; if (err_code !== 2'd2 || err_count !== 8'd4) begin bad++; $display("FAIL digits got=%0d/%0d want=2/4", err_code, err_count); end
    send_line("\r");
    send_line("");
    drain();
    total++; if (err_count !== 8'd4) begin bad++; $display("FAIL blank_lines got=%0d want=4", err_count); end
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL err_out_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_out[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_err_q.size() !== exp_err_q.size()) begin bad++; $display("FAIL err_events got=%0d want=%0d", obs_err_q.size(), exp_err_q.size()); end
    for (int i = 0; i < exp_err_q.size() && i < obs_err_q.size(); i++) begin
      total++; if (obs_err_q[i] !== exp_err_q[i]) begin bad++; $display("FAIL err_ev[%0d] got=%h want=%h", i, obs_err_q[i], exp_err_q[i]); end
    end
    total++; if (obs_viol !== 0 || stalls !== 0) begin bad++; $display("FAIL err_hs got=%0d/%0d want=0/0", obs_viol, stalls); end
  endtask

  task automatic test_backpressure();
    clear_sb();
    out_ready = 1'b0;
    send_line("count=42");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_data !== 8'd42 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%b want=1/42/0", c, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b want=1/0", in_ready, out_valid); end
    drain();
    total++; if (obs_q.size() !== 1 || exp_q.size() !== 1) begin bad++; $display("FAIL bp_count got=%0d want=1", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL bp_value got=%0d want=%0d", obs_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    string lines[5] = '{"count=007", "count=0007", "count=1\r", "count=99", "count=18"};
    clear_sb();
    foreach (lines[i]) send_line(lines[i]);
    drain();
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_out[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_err_q.size() !== 1 || exp_err_q.size() !== 1) begin bad++; $display("FAIL b2b_err_count got=%0d want=1", obs_err_q.size()); end
    else begin
      total++; if (obs_err_q[0] !== exp_err_q[0]) begin bad++; $display("FAIL b2b_err got=%h want=%h", obs_err_q[0], exp_err_q[0]); end
    end
  endtask

  task automatic test_mid_reset();
    string part = "count=1";
    clear_sb();
    for (int i = 0; i < part.len(); i++) send_char(part[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_err_cnt = 0;
    @(negedge clk);
    total++; if (err !== 1'b0 || err_code !== 2'd0 || err_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%b/%0d/%0d/%b/%b/%0d", err, err_code, err_count, out_valid, in_ready, out_data);
    end
    @(posedge clk);
    #1;
    send_line("2");
    drain();
    total++; if (err_code !== 2'd1 || err_count !== 8'd1) begin bad++; $display("FAIL midrst_prefix got=%0d/%0d want=1/1", err_code, err_count); end
    total++; if (obs_q.size() !== 0 || obs_err_q.size() !== exp_err_q.size()) begin bad++; $display("FAIL midrst_events got=%0d/%0d want=0/%0d", obs_q.size(), obs_err_q.size(), exp_err_q.size()); end
  endtask

  task automatic test_random();
    string s;
    string junk = "+- ax";
    int    p;
    clear_sb();
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: begin
          s = $sformatf("%0d", $urandom_range(0, 300));
          if ($urandom_range(0, 3) == 0) s = {"0", s};
          s = {"count=", s};
        end
        3: begin
          s = "count=5";
          s.putc($urandom_range(0, 5), 8'($urandom_range(97, 122)));
        end
        4: begin
          s = {"count=", $sformatf("%0d", $urandom_range(0, 9)), " "};
          s.putc(s.len() - 1, junk[$urandom_range(0, 4)]);
        end
        5: begin
          p = $urandom_range(0, 2);
          s = (p == 0) ? "count=" : (p == 1) ? "" : "coun";
        end
        default: begin
          s = $sformatf("count=%0d", $urandom_range(0, 255));
          p = $urandom_range(1, s.len() - 1);
          s = {s.substr(0, p - 1), "\r", s.substr(p, s.len() - 1)};
        end
      endcase
      send_line(s);
    end
    drain();
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
    out_ready  = 1'b1;
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_out_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_out[%0d] got=%0d want=%0d", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_err_q.size() !== exp_err_q.size()) begin bad++; $display("FAIL rnd_err_count got=%0d want=%0d", obs_err_q.size(), exp_err_q.size()); end
    for (int i = 0; i < exp_err_q.size() && i < obs_err_q.size(); i++) begin
      total++; if (obs_err_q[i] !== exp_err_q[i]) begin bad++; $display("FAIL rnd_err[%0d] got=%h want=%h", i, obs_err_q[i], exp_err_q[i]); end
    end
    total++; if (obs_viol !== 0 || stalls !== 0) begin bad++; $display("FAIL rnd_hs got=%0d/%0d want=0/0", obs_viol, stalls); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
